// File: rtl/core_wakeup_pkg.sv
// Shared types for the per-tile core wake-up sequencer.
package core_wakeup_pkg;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StSleep = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StHold  = 3'd4
    } wakeup_state_e;

    // Bits needed to count 0..max-1 over the three phase lengths, never below one.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/core_wakeup_ctrl.sv
// Core reset sequencer: SRAM-init wait, optional wake-IRQ gate, soft-reset drain/hold/ack.
// Define CORE_WAKEUP_IRQ_GATE_EN to hold the core in SLEEP until the first wake interrupt.
module core_wakeup_ctrl
    import core_wakeup_pkg::*;
#(
    parameter int unsigned WaitCycles  = 32768,
    parameter int unsigned DrainCycles = 256,
    parameter int unsigned HoldCycles  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sram_init_done_i,
    input  logic       wake_irq_i,
    input  logic       soft_rst_req_i,
    input  logic       core_idle_i,
    output logic       core_rst_no,
    output logic       soft_rst_ack_o,
    output logic       drain_timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntWidth = cnt_width(WaitCycles, DrainCycles, HoldCycles);
    localparam logic [CntWidth-1:0] WaitLast  = CntWidth'(WaitCycles - 1);
    localparam logic [CntWidth-1:0] DrainLast = CntWidth'(DrainCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(HoldCycles - 1);

`ifdef CORE_WAKEUP_IRQ_GATE_EN
    localparam wakeup_state_e InitExit = StSleep;
    logic wake_pending_q, wake_pending_d;
`else
    localparam wakeup_state_e InitExit = StRun;
    logic unused_wake_irq;
    assign unused_wake_irq = wake_irq_i;
`endif

    wakeup_state_e        state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 core_rst_q, core_rst_d;
    logic                 ack_q, ack_d;
    logic                 timeout_q, timeout_d;
    logic                 req_armed_q, req_armed_d;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit: begin
                if (cnt_q == WaitLast && sram_init_done_i) state_d = InitExit;
            end
`ifdef CORE_WAKEUP_IRQ_GATE_EN
            StSleep: begin
                if (wake_irq_i || wake_pending_q) state_d = StRun;
            end
`endif
            StRun: begin
                if (soft_rst_req_i && req_armed_q) state_d = StDrain;
            end
            StDrain: begin
                if (core_idle_i || cnt_q == DrainLast) state_d = StHold;
            end
            StHold: begin
                if (cnt_q == HoldLast) state_d = StRun;
            end
            default: state_d = StInit;
        endcase
    end

    // Shared phase counter: cleared on any state change, saturating per phase
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                StInit:  if (cnt_q != WaitLast)  cnt_d = cnt_q + CntWidth'(1);
                StDrain: if (cnt_q != DrainLast) cnt_d = cnt_q + CntWidth'(1);
                StHold:  if (cnt_q != HoldLast)  cnt_d = cnt_q + CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Output and flag next-state logic, all driven from transitions
    always_comb begin
        core_rst_d  = core_rst_q;
        ack_d       = 1'b0;
        timeout_d   = timeout_q;
        req_armed_d = req_armed_q;
        if (state_d == StRun && state_q != StRun) core_rst_d = 1'b1;
        if (state_d == StHold && state_q != StHold) begin
            core_rst_d = 1'b0;
            timeout_d  = !core_idle_i;
        end
        if (state_q == StHold && state_d == StRun) ack_d = 1'b1;
        // A held request must drop at least once before it can trigger again
        if (!soft_rst_req_i) begin
            req_armed_d = 1'b1;
        end else if (ack_d) begin
            req_armed_d = 1'b0;
        end
    end

`ifdef CORE_WAKEUP_IRQ_GATE_EN
    always_comb begin
        wake_pending_d = wake_pending_q;
        if (state_q == StInit && wake_irq_i) wake_pending_d = 1'b1;
        if (state_d == StRun && state_q != StRun) wake_pending_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wake_pending_q <= 1'b0;
        end else begin
            wake_pending_q <= wake_pending_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            core_rst_q  <= 1'b0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
            req_armed_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            core_rst_q  <= core_rst_d;
            ack_q       <= ack_d;
            timeout_q   <= timeout_d;
            req_armed_q <= req_armed_d;
        end
    end

    assign core_rst_no     = core_rst_q;
    assign soft_rst_ack_o  = ack_q;
    assign drain_timeout_o = timeout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_core_wakeup_ctrl.sv
// Self-checking bench for core_wakeup_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_core_wakeup_ctrl;
    import core_wakeup_pkg::*;

    localparam int unsigned WaitCycles  = 16;
    localparam int unsigned DrainCycles = 8;
    localparam int unsigned HoldCycles  = 4;
`ifdef CORE_WAKEUP_IRQ_GATE_EN
    localparam bit GateEn = 1'b1;
`else
    localparam bit GateEn = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sram_init_done_i = 1'b0;
    logic       wake_irq_i = 1'b0;
    logic       soft_rst_req_i = 1'b0;
    logic       core_idle_i = 1'b0;
    logic       core_rst_no;
    logic       soft_rst_ack_o;
    logic       drain_timeout_o;
    logic [2:0] state_o;

    always #5 clk_i = ~clk_i;

    core_wakeup_ctrl #(
        .WaitCycles  (WaitCycles),
        .DrainCycles (DrainCycles),
        .HoldCycles  (HoldCycles)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .sram_init_done_i (sram_init_done_i),
        .wake_irq_i       (wake_irq_i),
        .soft_rst_req_i   (soft_rst_req_i),
        .core_idle_i      (core_idle_i),
        .core_rst_no      (core_rst_no),
        .soft_rst_ack_o   (soft_rst_ack_o),
        .drain_timeout_o  (drain_timeout_o),
        .state_o          (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // Behavioural model: time spent in each phase is tracked as an unbounded age
    wakeup_state_e m_state;
    int            m_age;
    bit            m_core_on, m_ack, m_timeout, m_wake_seen, m_may_req;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", tag, act, exp,
                     edge_cnt, $time);
        end
    endtask

    function automatic void model_reset();
        m_state     = StInit;
        m_age       = 0;
        m_core_on   = 1'b0;
        m_ack       = 1'b0;
        m_timeout   = 1'b0;
        m_wake_seen = 1'b0;
        m_may_req   = 1'b1;
    endfunction

    function automatic void model_step(bit sram, bit wake, bit req, bit idle);
        wakeup_state_e nxt;
        nxt   = m_state;
        m_ack = 1'b0;
        case (m_state)
            StInit: begin
                if (GateEn && wake) m_wake_seen = 1'b1;
                if (m_age >= int'(WaitCycles) - 1 && sram) nxt = GateEn ? StSleep : StRun;
            end
            StSleep: if (wake || m_wake_seen) nxt = StRun;
            StRun:   if (req && m_may_req) nxt = StDrain;
            StDrain: begin
                if (idle) begin
                    nxt = StHold;
                    m_timeout = 1'b0;
                end else if (m_age >= int'(DrainCycles) - 1) begin
                    nxt = StHold;
                    m_timeout = 1'b1;
                end
            end
            StHold: begin
                if (m_age >= int'(HoldCycles) - 1) begin
                    nxt = StRun;
                    m_ack = 1'b1;
                end
            end
            default: nxt = StInit;
        endcase
        if (!req) m_may_req = 1'b1;
        else if (m_ack) m_may_req = 1'b0;
        if (nxt != m_state) begin
            m_age = 0;
            if (nxt == StRun) begin
                m_core_on   = 1'b1;
                m_wake_seen = 1'b0;
            end
            if (nxt == StHold) m_core_on = 1'b0;
        end else begin
            m_age++;
        end
        m_state = nxt;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        if (rst_ni) begin
            model_step(sram_init_done_i, wake_irq_i, soft_rst_req_i, core_idle_i);
            edge_cnt++;
        end
        #1;
        check_eq("state", state_o, m_state);
        check_eq("core_rst_n", core_rst_no, m_core_on);
        check_eq("ack", soft_rst_ack_o, m_ack);
        check_eq("drain_timeout", drain_timeout_o, m_timeout);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_state", state_o, StInit);
        check_eq("rst_core_rst_n", core_rst_no, 0);
        check_eq("rst_ack", soft_rst_ack_o, 0);
        check_eq("rst_timeout", drain_timeout_o, 0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        release_reset();
    endtask

    // Reset asserted between edges must take effect without a clock
    task automatic async_reset();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_eq("async_state", state_o, StInit);
        check_eq("async_core_rst_n", core_rst_no, 0);
        check_eq("async_ack", soft_rst_ack_o, 0);
        check_eq("async_timeout", drain_timeout_o, 0);
        release_reset();
    endtask

    task automatic run_init(input int sram_at, input string tag);
        int  rise;
        logic prev;
        rise = -1;
        prev = core_rst_no;
        for (int i = 0; i < sram_at + 30; i++) begin
            sram_init_done_i = (edge_cnt >= sram_at);
            wake_irq_i       = GateEn && (edge_cnt == 4);
            cyc();
            if (edge_cnt == int'(WaitCycles) - 1) check_eq({tag, "_pre_state"}, state_o, StInit);
            if (core_rst_no && !prev && rise < 0) rise = edge_cnt;
            prev = core_rst_no;
        end
        wake_irq_i = 1'b0;
        check_eq({tag, "_rise_edge"}, rise,
                 (sram_at > int'(WaitCycles) - 1 ? sram_at + 1 : int'(WaitCycles)) + int'(GateEn));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks, lows, drains;
        // 1/3: SRAM ready from reset
        sram_init_done_i = 1'b1;
        do_reset();
        run_init(0, "s1");

        // 2: SRAM ready late
        sram_init_done_i = 1'b0;
        do_reset();
        run_init(40, "s2");
        sram_init_done_i = 1'b0;

        // 4: held request with idle core, served once
        soft_rst_req_i = 1'b1;
        core_idle_i    = 1'b1;
        acks = 0; lows = 0; drains = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (soft_rst_ack_o) begin
                acks++;
                check_eq("s4_ack_with_rise", core_rst_no, 1);
            end
            if (!core_rst_no) lows++;
            if (state_o == StDrain) drains++;
        end
        check_eq("s4_acks", acks, 1);
        check_eq("s4_hold_len", lows, HoldCycles);
        check_eq("s4_drain_len", drains, 1);
        check_eq("s4_timeout", drain_timeout_o, 0);

        // 5: busy core forces drain timeout, then an idle drain clears it
        soft_rst_req_i = 1'b0;
        core_idle_i    = 1'b0;
        cyc();
        soft_rst_req_i = 1'b1;
        cyc();
        soft_rst_req_i = 1'b0;
        drains = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (state_o == StDrain) drains++;
        end
        check_eq("s5_drain_len", drains + 1, DrainCycles);
        check_eq("s5_timeout_set", drain_timeout_o, 1);
        core_idle_i    = 1'b1;
        soft_rst_req_i = 1'b1;
        repeat (10) cyc();
        soft_rst_req_i = 1'b0;
        cyc();
        check_eq("s5_timeout_clr", drain_timeout_o, 0);

        // 6: reset asserted during HOLD
        soft_rst_req_i = 1'b1;
        for (int i = 0; i < 20 && state_o != StHold; i++) cyc();
        check_eq("s6_hold_reached", state_o, StHold);
        async_reset();
        soft_rst_req_i   = 1'b0;
        sram_init_done_i = 1'b1;
        run_init(0, "s6");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sram_init_done_i = ($urandom_range(0, 7) != 0);
            wake_irq_i       = ($urandom_range(0, 15) == 0);
            core_idle_i      = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) soft_rst_req_i = ~soft_rst_req_i;
            cyc();
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_wakeup_ctrl.md
Name: core_wakeup_ctrl

Overview:
Per-tile sequencer for the core reset line.
- Holds the core in reset until the OpenPiton SRAMs have initialised, then releases it.
- Optionally waits for the initial wake-up interrupt before releasing.
- Serves soft-reset requests by draining outstanding memory traffic, pulsing core reset, and acknowledging the requester.
- Sits between the tile reset and the core reset-synchroniser input. All inputs are already synchronised to clk_i.

Parameters:
- WaitCycles, 32768, minimum cycles in INIT after rst_ni deasserts.
- DrainCycles, 256, drain timeout in cycles.
- HoldCycles, 16, cycles core_rst_no is held low during a soft reset.
- CntWidth, $clog2(max(WaitCycles,DrainCycles,HoldCycles)), derived localparam, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset (already decided).
- sram_init_done_i  in  1  level; tile SRAM initialisation complete.
- wake_irq_i  in  1  single-cycle pulse; L15 interrupt return with valid.
- soft_rst_req_i  in  1  level; soft-reset request.
- core_idle_i  in  1  level; core has no outstanding memory transactions.
- core_rst_no  out  1  registered active-low core reset.
- soft_rst_ack_o  out  1  one-cycle acknowledge pulse.
- drain_timeout_o  out  1  sticky flag: last drain ended by timeout.
- state_o  out  3  current state encoding.

Behaviour:
- Reset values: state INIT, counter 0, core_rst_no=0, soft_rst_ack_o=0, drain_timeout_o=0, wake_pending=0, req_armed=1.
- State encoding: INIT=0, SLEEP=1, RUN=2, DRAIN=3, HOLD=4. Values 5-7 are unreachable and recover to INIT.
- One shared counter. It clears on every state entry and increments each cycle in INIT/DRAIN/HOLD, saturating at its terminal value.
- INIT:
  - Counter runs 0..WaitCycles-1.
  - Exit when counter==WaitCycles-1 AND sram_init_done_i. The target is SLEEP or RUN (see Optional Feature).
  - If sram_init_done_i is still low at terminal count, stay in INIT with the counter saturated.
- core_rst_no is a register. It is set on the edge that enters RUN and cleared on the edge that enters HOLD. It is never combinationally derived from state.
  - Without the optional feature, core_rst_no rises at clock edge WaitCycles after rst_ni deasserts, given sram_init_done_i is high.
- RUN:
  - If soft_rst_req_i && req_armed, go to DRAIN.
  - sram_init_done_i changes are ignored once INIT is left.
- DRAIN:
  - If core_idle_i, go to HOLD and clear drain_timeout_o.
  - Else if counter==DrainCycles-1, go to HOLD and set drain_timeout_o.
  - core_idle_i high on the entry cycle exits on the next edge (DRAIN lasts 1 cycle).
  - Deasserting soft_rst_req_i during DRAIN does not abort it.
- HOLD:
  - core_rst_no=0 for exactly HoldCycles cycles.
  - On counter==HoldCycles-1, go to RUN (core_rst_no rises) with soft_rst_ack_o high for that one cycle, and clear req_armed.
  - Soft reset never re-enters INIT or SLEEP.
- req_armed is set again on any cycle soft_rst_req_i is low. A request held high after ack therefore does not retrigger.
- soft_rst_req_i during INIT/SLEEP is ignored, not queued. The requester keeps it high and it is served on reaching RUN.
- rst_ni assertion mid-operation (any state) forces the reset values immediately and asynchronously.

Optional Feature:
- Macro: CORE_WAKEUP_IRQ_GATE_EN.
- Defined:
  - INIT exits to SLEEP.
  - SLEEP goes to RUN on wake_irq_i or wake_pending.
  - wake_pending is a sticky flag set by wake_irq_i seen in INIT, so an early wake is not lost. It is cleared on entering RUN.
  - wake_irq_i is ignored in RUN/DRAIN/HOLD.
- Undefined:
  - INIT exits directly to RUN.
  - SLEEP is unreachable; encoding 1 recovers to INIT.
  - wake_irq_i is unused, and wake_pending is not instantiated.

Decomposition:
- Package core_wakeup_pkg holds the state enum typedef (logic [2:0]) and its encodings, shared by RTL and bench.
- No sub-module: the counter and FSM are inline.
- Synchronisation of inputs stays outside, using the existing synchronizer cells.

Test Plan:
Bench parameters: WaitCycles=16, DrainCycles=8, HoldCycles=4.
1. Macro off; sram_init_done_i=1 from reset; release rst_ni -> core_rst_no rises at edge 16; state_o goes 0->2.
2. Macro off; sram_init_done_i rises at cycle 40 -> state_o stays 0 with counter saturated; core_rst_no rises at edge 41.
3. Macro on; wake_irq_i pulse at cycle 5, none later -> state_o 0->1 at edge 16, 1->2 at edge 17.
4. In RUN: soft_rst_req_i=1 held, core_idle_i=1 -> DRAIN 1 cycle, core_rst_no low for 4 cycles, soft_rst_ack_o pulse coincident with core_rst_no rising, drain_timeout_o=0; req held high for 20 more cycles -> no second drain.
5. In RUN: core_idle_i=0, pulse request -> HOLD entered after 8 DRAIN cycles, drain_timeout_o=1; next request with core_idle_i=1 -> drain_timeout_o=0.
6. Assert rst_ni during HOLD -> core_rst_no=0, soft_rst_ack_o=0, state_o=0 immediately; full INIT sequence repeats.
